uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte FIFO between the system-side byte producer and the UART transmitter. It buffers up to 2^DEPTH_LOG2 bytes and presents the head byte with a valid/acknowledge handshake. The transmitter latches `tx_byte` and pulses `tx_ack` when it enters its start-bit state. Writes while full are dropped and flagged, so producers without backpressure remain safe.

## Interface
- `DEPTH_LOG2`, default 4: log2 of the storage depth (16 entries); legal range 1..8.
- `clock` in 1: the single clock; all state is updated on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `wr_valid` in 1: producer offers `wr_data` this cycle.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: equals `!full`, registered from state.
- `tx_valid` out 1: FIFO non-empty; `tx_byte` holds the head byte.
- `tx_byte` out 8: head byte, stable while `tx_valid` is high and no pop occurs.
- `tx_ack` in 1: one-cycle pulse from the transmitter that pops the head.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky flag, set when a write is dropped.
- `clear_overflow` in 1: synchronous clear of `overflow`.
- `drop_count` out 8: present only with `UART_TX_FIFO_DROP_COUNT_EN` (see Configuration).

## Operation
- Pointers `wr_ptr` and `rd_ptr` are DEPTH_LOG2+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - `count` = `wr_ptr - rd_ptr`, computed modulo 2^(DEPTH_LOG2+1).
- Push occurs when `wr_valid && !full`: the memory at `wr_ptr` is written and `wr_ptr` increments.
- Drop occurs when `wr_valid && full`:
  - The data is discarded and `overflow` is set.
  - This holds even if `tx_ack` pops in the same cycle; full-ness is judged on pre-edge state.
- Pop occurs when `tx_ack && tx_valid`: `rd_ptr` increments. A `tx_ack` while empty is ignored, with no pointer change and no flag.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen and `count` is unchanged.
- Simultaneous push and ack on an empty FIFO: the ack is ignored and the push is accepted.
- `overflow` priority: a set in the same cycle as `clear_overflow` wins, so the flag stays 1.
- Wrap-around: pointers roll over naturally at 2^(DEPTH_LOG2+1); no special case is required.
- Reset mid-operation: contents are abandoned and the FIFO returns to empty immediately (asynchronously).

## Timing
- Reset values:
  - `wr_ready` = 1, `tx_valid` = 0, `tx_byte` = 8'h00.
  - `count` = 0, `overflow` = 0, `drop_count` = 0.
  - Both pointers = 0.
- Write-to-read latency: a push in cycle N gives `tx_valid` = 1 in N+1, with `tx_byte` equal to the pushed byte when the FIFO was empty.
- Pop with data remaining: the next head appears on `tx_byte` in the cycle after `tx_ack`.
- Pop of the last entry: `tx_valid` falls in the cycle after `tx_ack`.
- Full timing: `wr_ready` falls the cycle after the push that fills the FIFO, and rises the cycle after the first pop from full.
- `tx_byte` is a registered show-ahead output. It is driven from a head register updated on push-into-empty and on pop; there is no combinational path from the memory read to the output.
- No combinational path exists from any input to any output.

## Configuration
- `UART_TX_FIFO_DROP_COUNT_EN` defined:
  - Adds the `drop_count` output, an 8-bit count of dropped writes.
  - It saturates at 8'hFF.
  - It is cleared by `clear_overflow`; a drop in the same cycle as the clear yields 1.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `uart_pkg` holds:
  - the `UART_BYTE_W` = 8 constant;
  - the `uart_byte_t` typedef;
  - the default FIFO depth constant.
- One sub-module, `uart_fifo_mem`, provides 2^DEPTH_LOG2 x 8 storage:
  - synchronous write, asynchronous read;
  - no reset on storage.
- Pointer, flag and head-register logic lives in `uart_tx_fifo`.

## Test plan
- Reset with `reset_n` = 0, then release → `tx_valid` = 0, `wr_ready` = 1, `count` = 0, `overflow` = 0.
- Push 8'h41 into the empty FIFO → next cycle `tx_valid` = 1, `tx_byte` = 8'h41, `count` = 1. Then pulse `tx_ack` → next cycle `tx_valid` = 0, `count` = 0.
- Push 16 bytes 8'h00..8'h0F with `DEPTH_LOG2` = 4 → `count` = 16, `wr_ready` = 0. A 17th push of 8'hFF → `overflow` = 1, `count` stays 16. Popping all 16 returns 8'h00..8'h0F in order, and 8'hFF never appears.
- Run 40 pushes interleaved with 40 pops, occupancy ≤ 3 (pointer wrap twice) → data out in order, `count` correct every cycle.
- Full FIFO with `wr_valid` and `tx_ack` in the same cycle → write dropped, `overflow` = 1, `count` = 15. With the macro defined, `drop_count` = 1.
- Assert `reset_n` = 0 asynchronously mid-stream with `count` = 5 → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type and default TX FIFO depth.
package uart_pkg;

  localparam int unsigned UART_BYTE_W          = 8;
  localparam int unsigned UART_FIFO_DEPTH_LOG2 = 4;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART TX FIFO: 2^ADDR_W x 8, synchronous write,
// asynchronous read, no reset on contents.
// Ports:
//   clock     - write clock
//   wr_en     - write strobe
//   wr_addr   - write address
//   wr_data   - byte to store
//   rd_addr   - read address
//   rd_data_c - combinational read data at rd_addr
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = UART_FIFO_DEPTH_LOG2
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  uart_byte_t        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output uart_byte_t        rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  uart_byte_t mem [DEPTH];

  // Storage write
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter with a registered show-ahead head.
// Writes while full are dropped and flagged in a sticky overflow bit.
// Optional feature macro: UART_TX_FIFO_DROP_COUNT_EN adds a saturating
// 8-bit drop counter output (drop_count).
// Ports:
//   clock, reset_n  - clock, async active-low reset
//   wr_valid/wr_data - producer write (no backpressure required)
//   wr_ready        - registered !full
//   tx_valid/tx_byte - registered head byte presented to the transmitter
//   tx_ack          - pops the head
//   count           - registered occupancy
//   overflow        - sticky drop flag, cleared by clear_overflow
//   drop_count      - dropped-write counter (macro only)
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_valid,
  input  uart_byte_t          wr_data,
  output logic                wr_ready,
  output logic                tx_valid,
  output uart_byte_t          tx_byte,
  input  logic                tx_ack,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow,
`ifdef UART_TX_FIFO_DROP_COUNT_EN
  output logic [7:0]          drop_count,
`endif
  input  logic                clear_overflow
);

  localparam int unsigned ADDR_W = DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt, rd_ptr_inc;
  logic             full_c, empty_c, full_nxt_c;
  logic             push_c, pop_c, drop_c;
  uart_byte_t       head_nxt_c, mem_rd_c;

  // Full/empty judged on pre-edge pointer state
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign push_c = wr_valid && !full_c;
  assign drop_c = wr_valid && full_c;
  assign pop_c  = tx_ack && !empty_c;

  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign wr_ptr_nxt = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign rd_ptr_nxt = pop_c ? rd_ptr_inc : rd_ptr;

  assign full_nxt_c = (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]) &&
                      (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]);

  // Memory read port looks one entry past the head to pre-fetch the next byte
  uart_fifo_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .wr_en     (push_c),
    .wr_addr   (wr_ptr[ADDR_W-1:0]),
    .wr_data   (wr_data),
    .rd_addr   (rd_ptr_inc[ADDR_W-1:0]),
    .rd_data_c (mem_rd_c)
  );

  // Head register: on pop take the next stored entry, or bypass the incoming
  // byte when the popped entry was the last one and a push arrives together
  always_comb begin
    head_nxt_c = tx_byte;
    if (pop_c) begin
      if (rd_ptr_inc != wr_ptr) begin
        head_nxt_c = mem_rd_c;
      end else if (push_c) begin
        head_nxt_c = wr_data;
      end
    end else if (push_c && empty_c) begin
      head_nxt_c = wr_data;
    end
  end

  // Pointers and registered status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
      count    <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ready <= !full_nxt_c;
      tx_valid <= (wr_ptr_nxt != rd_ptr_nxt);
      tx_byte  <= head_nxt_c;
      count    <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  // Sticky overflow; a drop beats a simultaneous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_DROP_COUNT_EN
  // Saturating drop counter; a drop coinciding with clear restarts at 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (clear_overflow) begin
      drop_count <= drop_c ? 8'd1 : 8'd0;
    end else if (drop_c && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus scoreboarded
// multi-cycle sequences (fill/overflow/drain, wrap, full push+pop, async reset).
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_ack;
  logic [DL2:0] count;
  logic       overflow;
  logic       clear_overflow;
`ifdef UART_TX_FIFO_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .tx_valid       (tx_valid),
    .tx_byte        (tx_byte),
    .tx_ack         (tx_ack),
    .count          (count),
    .overflow       (overflow),
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    .drop_count     (drop_count),
`endif
    .clear_overflow (clear_overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [7:0] sb[$];
  int         m_count;
  logic       m_ovf;
  int         m_drops;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       ack;
    logic       clr;
    logic       e_valid;
    int         e_count;
    logic [7:0] e_byte;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(m_count != 0));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(m_count != DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (m_count > 0) chk({tag, ".tx_byte"}, 32'(tx_byte), 32'(sb[0]));
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // One clock: drive at negedge, update the model, check 1ns after posedge
  task automatic step(input string tag, input logic wv, input logic [7:0] wd,
                      input logic ack, input logic clr);
    bit full, drop, push, pop;
    @(negedge clock);
    wr_valid = wv; wr_data = wd; tx_ack = ack; clear_overflow = clr;
    full = (m_count == DEPTH);
    drop = wv && full;
    push = wv && !full;
    pop  = ack && (m_count > 0);
    if (pop) begin
      chk({tag, ".sb_pop"}, 32'(tx_byte), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (push) sb.push_back(wd);
    m_count = m_count + int'(push) - int'(pop);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 255) m_drops++;
    @(posedge clock);
    #1;
    check_state(tag);
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_data = 8'h00; tx_ack = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0; m_ovf = 1'b0; m_drops = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, ".tx_byte"}, 32'(tx_byte), 32'h00);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    chk({tag, ".drop_count"}, 32'(drop_count), 32'd0);
`endif
  endtask

  initial begin
    // Basic handshake table from an empty FIFO
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 1, 8'h41, 1'b0}; // push into empty
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0}; // pop last
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0}; // ack while empty
    vecs[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1, 8'h5A, 1'b0}; // push+ack on empty
    vecs[4] = '{1'b1, 8'h6B, 1'b0, 1'b0, 1'b1, 2, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 8'h7C, 1'b1, 1'b0, 1'b1, 2, 8'h6B, 1'b0}; // push+pop, count kept
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 8'h7C, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0}; // clear with no drop

    idle_inputs();
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].wv, vecs[i].wd, vecs[i].ack, vecs[i].clr);
      chk($sformatf("vec%0d.e_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.e_valid", i), 32'(tx_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.e_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].e_valid) chk($sformatf("vec%0d.e_byte", i), 32'(tx_byte), 32'(vecs[i].e_byte));
    end

    // Fill to 16, drop a 17th, drain in order
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("full.count", 32'(count), 32'd16);
    chk("full.wr_ready", 32'(wr_ready), 32'd0);
    step("drop17", 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop17.overflow", 32'(overflow), 32'd1);
    chk("drop17.count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.order", 32'(tx_byte), 32'(i));
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained.valid", 32'(tx_valid), 32'd0);
    step("clear", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clear.overflow", 32'(overflow), 32'd0);

    // 40 pushes interleaved with pops, occupancy small, pointers wrap
    for (int i = 0; i < 40; i++)
      step("wrap", 1'b1, 8'(i * 7 + 3), (m_count >= 2) ? 1'b1 : 1'b0, 1'b0);
    while (m_count > 0) step("wrap_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full FIFO with write and ack together: write dropped, pop taken
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step("full_wr_ack", 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("full_wr_ack.count", 32'(count), 32'd15);
    chk("full_wr_ack.overflow", 32'(overflow), 32'd1);
`ifdef UART_TX_FIFO_DROP_COUNT_EN
    chk("full_wr_ack.drop_count", 32'(drop_count), 32'd1);
`endif
    // Drop coincident with clear: flag stays set
    step("top_up", 1'b1, 8'h90, 1'b0, 1'b0);
    step("drop_clr", 1'b1, 8'hDD, 1'b0, 1'b1);
    chk("drop_clr.overflow", 32'(overflow), 32'd1);

    // Async reset mid-stream with count = 5
    while (m_count > 0) step("pre_rst_drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("five", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    idle_inputs();
    chk("five.count", 32'(count), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    step("after_rst_push", 1'b1, 8'h33, 1'b0, 1'b0);
    step("after_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
